// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache miss-path memory responder.
// These are the line geometry constants, the latency counter width and the
// responder FSM state encoding.
package cache_mem_pkg;

    localparam int LINE_W         = 128;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = LINE_W / WORD_W;
    localparam int LINE_ADDR_W    = 13;
    localparam int DEPTH          = 2 ** LINE_ADDR_W;

    // Counter holds LATENCY-1, and LATENCY is at most 15.
    localparam int CNT_W          = 4;
    localparam int LATENCY_MIN    = 1;
    localparam int LATENCY_MAX    = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: single-port synchronous line RAM, LINE_W bits x DEPTH lines.
//  Read data is registered: rdata_o shows mem_q[addr_i] one cycle after addr_i.
//  A write and a read in the same cycle return the old contents.
//  Contents have no reset. Initial contents are loaded into mem_q from outside,
//  for example by a hierarchical assignment from the testbench.
// Ports:
//  clk_i    in   clock, rising edge
//  we_i     in   write enable for the addressed line
//  addr_i   in   line address (ADDR_W bits)
//  wdata_i  in   write line data
//  rdata_o  out  registered read line data
module mem_line_array #(
    parameter int LINE_W = cache_mem_pkg::LINE_W,
    parameter int ADDR_W = cache_mem_pkg::LINE_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);
    import cache_mem_pkg::*;

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_fill_memory.sv
// line_fill_memory: main-memory responder on the cache miss path.
//  It accepts one line request at a time. It waits LATENCY cycles from the accept
//  and then presents the line on rsp_* until the cache takes it.
//  Optional feature macro: MEM_WRITE_EN.
//   When it is defined, req_wr=1 writes req_wdata into the line and the response
//   carries rsp_rdata=0.
//   When it is undefined, the array is read-only, every request is a read, and the
//   RAM write enable is tied low.
// Ports:
//  globalclock in   clock, rising edge
//  reset       in   asynchronous, active-high
//  req_valid   in   request present
//  req_ready   out  responder idle and able to accept
//  req_wr      in   1 = line write, 0 = line read
//  req_addr    in   line address (wraps modulo DEPTH)
//  req_wdata   in   write line data
//  rsp_valid   out  response present
//  rsp_ready   in   cache accepts response
//  rsp_rdata   out  read line data (zero for write responses)
//  busy        out  responder not idle
//
// state   | meaning
// ST_IDLE | ready for a request; request fields are latched on accept
// ST_WAIT | latency countdown; array access happens when the counter hits 0
// ST_RESP | response held on rsp_* until rsp_valid & rsp_ready
module line_fill_memory #(
    parameter int LINE_ADDR_W = cache_mem_pkg::LINE_ADDR_W,
    parameter int LINE_W      = cache_mem_pkg::LINE_W,
    parameter int LATENCY     = 4,
    parameter int DEPTH       = 2 ** LINE_ADDR_W
) (
    input  logic                   globalclock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wr,
    input  logic [LINE_ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [LINE_W-1:0]      rsp_rdata,
    output logic                   busy
);
    import cache_mem_pkg::*;

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("line_fill_memory: LATENCY must be within 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    mem_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LINE_ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]      rdata_q, rdata_d;

    logic                   line_wr;
    logic                   ram_we;
    logic [LINE_ADDR_W-1:0] ram_addr;
    logic [LINE_W-1:0]      ram_wdata;
    logic [LINE_W-1:0]      ram_rdata;

    // In IDLE the RAM is addressed straight from the request port, so its
    // registered output is already valid for the latched address on the cycle
    // after the accept. This lets LATENCY=1 work with a registered-read RAM.
    assign ram_addr = (state_q == ST_IDLE) ? req_addr : addr_q;

`ifdef MEM_WRITE_EN
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    always_comb begin
        wr_d    = wr_q;
        wdata_d = wdata_q;
        if (state_q == ST_IDLE && req_valid) begin
            wr_d    = req_wr;
            wdata_d = req_wdata;
        end
    end

    always_ff @(posedge globalclock or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    assign line_wr   = wr_q;
    assign ram_wdata = wdata_q;
`else
    logic unused_wr_path;
    assign unused_wr_path = ^{req_wr, req_wdata};
    assign line_wr        = 1'b0;
    assign ram_wdata      = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        ram_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    // The write commits on the same edge that raises rsp_valid.
                    ram_we  = line_wr;
                    rdata_d = line_wr ? '0 : ram_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge globalclock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    mem_line_array #(
        .LINE_W (LINE_W),
        .ADDR_W (LINE_ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (globalclock),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_line_fill_memory.sv
`timescale 1ns/1ps
module tb_line_fill_memory;
    localparam int AW  = 13;
    localparam int LW  = 128;
    localparam int LAT = 4;

`ifdef MEM_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [LW-1:0] rsp_rdata;
    logic          busy;

    typedef struct {
        logic [LW-1:0] data;
        int            acc;
    } exp_t;

    exp_t          exp_q[$];
    logic [LW-1:0] model_mem [logic [AW-1:0]];
    logic [AW-1:0] pool [16];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int rdy_mode = 0;

    int            first_cyc = 0;
    bit            prev_valid = 1'b0;
    bit            prev_hs = 1'b0;
    logic [LW-1:0] prev_data = '0;

    line_fill_memory #(
        .LINE_ADDR_W (AW),
        .LINE_W      (LW),
        .LATENCY     (LAT),
        .DEPTH       (2 ** AW)
    ) dut (
        .globalclock (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got no event within bound, required one", name);
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // rsp_ready changes just after the rising edge, so it is stable at the negedge sampling point.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 3) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
            end else begin
                if (prev_hs) check("valid_drops_after_hs", LW'(rsp_valid), LW'(0));
                if (rsp_valid) begin
                    if (!prev_valid) first_cyc = cyc;
                    else check("rdata_stable", rsp_rdata, prev_data);
                    check("req_ready_low_in_resp", LW'(req_ready), LW'(0));
                    check("busy_in_resp", LW'(busy), LW'(1));
                    if (rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            fail_now("unexpected_response");
                        end else begin
                            e = exp_q.pop_front();
                            check("rsp_data", rsp_rdata, e.data);
                            check("rsp_latency", LW'(first_cyc - e.acc), LW'(LAT));
                        end
                    end
                end
                prev_valid = rsp_valid;
                prev_hs    = rsp_valid && rsp_ready;
                prev_data  = rsp_rdata;
            end
        end
    end

    // Drives one request and waits for it to be accepted. The expected
    // response comes from the model at the moment of accept.
    task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                          input bit commit, input bit hold);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail_now("req_accept_timeout");
            req_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        if (wr && WR_EN) begin
            e.data = '0;
            if (commit) model_mem[addr] = wdata;
        end else begin
            e.data = model_mem[addr];
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || rsp_valid) fail_now("drain_timeout");
    endtask

    initial begin
        logic [LW-1:0] d;
        logic [AW-1:0] a;
        bit            wr;
        int            n;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        pool[0] = 13'h000;
        pool[1] = 13'h001;
        pool[2] = 13'h002;
        pool[3] = 13'h010;
        pool[4] = 13'h0A5;
        pool[5] = 13'h1FFF;
        for (int i = 6; i < 16; i++) pool[i] = AW'($urandom_range(0, 8191));
        for (int i = 0; i < 16; i++) begin
            d = rand_line();
            if (pool[i] == 13'h0A5) d = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001;
            model_mem[pool[i]] = d;
            dut.u_array.mem_q[pool[i]] <= d;
        end

        @(negedge clk);
        @(negedge clk);
        check("reset_req_ready", LW'(req_ready), LW'(1));
        check("reset_rsp_valid", LW'(rsp_valid), LW'(0));
        check("reset_busy", LW'(busy), LW'(0));
        check("reset_rsp_rdata", rsp_rdata, LW'(0));
        reset = 1'b0;

        // Preloaded read.
        do_req(1'b0, 13'h0A5, '0, 1'b1, 1'b0);
        wait_idle();

        // Hold off the response for 6 cycles.
        rdy_mode = 2;
        do_req(1'b0, 13'h010, '0, 1'b1, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) fail_now("bp_rsp_valid_timeout");
        repeat (6) @(negedge clk);
        rdy_mode = 0;
        wait_idle();

        // A write followed by a read of the same line. In the read-only build
        // the line keeps its preloaded value.
        do_req(1'b1, 13'h1FFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 1'b0);
        do_req(1'b0, 13'h1FFF, '0, 1'b1, 1'b0);
        do_req(1'b1, 13'h010, rand_line(), 1'b1, 1'b0);
        do_req(1'b0, 13'h010, '0, 1'b1, 1'b0);
        wait_idle();

        // req_valid stays high across three reads.
        do_req(1'b0, 13'h000, '0, 1'b1, 1'b1);
        do_req(1'b0, 13'h001, '0, 1'b1, 1'b1);
        do_req(1'b0, 13'h002, '0, 1'b1, 1'b0);
        wait_idle();

        // Reset during WAIT drops the write.
        do_req(1'b1, 13'h0A5, rand_line(), 1'b0, 1'b0);
        @(negedge clk);
        check("busy_in_wait", LW'(busy), LW'(1));
        #1;
        reset = 1'b1;
        #1;
        check("midreset_rsp_valid", LW'(rsp_valid), LW'(0));
        check("midreset_req_ready", LW'(req_ready), LW'(1));
        check("midreset_busy", LW'(busy), LW'(0));
        check("midreset_rsp_rdata", rsp_rdata, LW'(0));
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        do_req(1'b0, 13'h0A5, '0, 1'b1, 1'b0);
        wait_idle();

        // Random traffic with random response backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            a  = pool[$urandom_range(0, 15)];
            wr = ($urandom_range(0, 2) == 0);
            do_req(wr, a, rand_line(), 1'b1, (i != 59) && ($urandom_range(0, 1) == 1));
        end
        req_valid = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
